hazard_controller: RTL and testbench

//  Pipeline hazard/stall controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB).

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 40 ++++
 rtl/hazard_controller.sv | 183 ++++++++++++++++++
 tb/tb_hazard_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, forwarding codes, hazard FSM states and the
// scoreboard entry type used by the hazard controller (HAZARD_FORWARDING_EN aware).
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int REGBITS = 5;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_UJ   = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic [REGBITS-1:0] rd;
        logic               wen;
        logic               is_load;
        logic               valid;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{rd: '0, wen: 1'b0, is_load: 1'b0, valid: 1'b0};

    // wen is only ever set for rd != x0, so x0 can never produce a match.
    function automatic logic sb_match(sb_entry_t e, logic [REGBITS-1:0] rs, logic used);
        return used && e.valid && e.wen && (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot shadow of the EX/MEM/WB destination registers; each slot shifts
// from its predecessor under its own enable and can be cleared to a bubble.
module hazard_scoreboard
    import riscv_pkg::*;
(
    input  logic       clock_i,
    input  logic       resetn_i,
    input  sb_entry_t  id_entry_i,
    input  logic [2:0] en_i,
    input  logic [2:0] clr_i,
    output sb_entry_t  slot_o [3]
);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slot
            sb_entry_t src;
            sb_entry_t q;

            if (gi == 0) begin : g_head
                assign src = id_entry_i;
            end else begin : g_tail
                assign src = g_slot[gi-1].q;
            end

            always_ff @(posedge clock_i or negedge resetn_i) begin
                if (!resetn_i) begin
                    q <= SB_EMPTY;
                end else if (clr_i[gi]) begin
                    q <= SB_EMPTY;
                end else if (en_i[gi]) begin
                    q <= src;
                end
            end

            assign slot_o[gi] = q;
        end
    endgenerate

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forwarding controller for the 5-stage RV32I pipeline; forwarding
// and load-use-only stalls are enabled by defining HAZARD_FORWARDING_EN.
module hazard_controller
    import riscv_pkg::*;
(
    input  logic            clock,
    input  logic            resetn,
    input  logic [XLEN-1:0] instruction,
    input  logic            PCSelR,
    input  logic            dmem_ready,
    output logic            PCEn,
    output logic            IFIDEn,
    output logic            En1,
    output logic            En2,
    output logic            En3,
    output logic            reset1,
    output logic            reset2,
    output logic            reset3,
    output logic            flush_ifid_n,
    output logic [1:0]      fwdA,
    output logic [1:0]      fwdB
);

    logic [6:0]         opcode;
    logic [REGBITS-1:0] rs1;
    logic [REGBITS-1:0] rs2;
    logic [REGBITS-1:0] rd;
    logic               use_rs1;
    logic               use_rs2;
    logic               rd_valid;
    sb_entry_t          id_entry;
    sb_entry_t          sb [3];
    logic [2:0]         hit;
    logic               stall_req;
    logic               redirect;
    hz_state_t          state_q;
    logic               unused_bits;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];

    always_comb begin
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        rd_valid = 1'b0;
        case (opcode)
            OP_R: begin
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                rd_valid = 1'b1;
            end
            OP_I, OP_LW, OP_JALR: begin
                use_rs1  = 1'b1;
                rd_valid = 1'b1;
            end
            OP_S, OP_BR: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_UJ:   rd_valid = 1'b1;
            default: ;
        endcase
    end

    assign id_entry = '{rd: rd, wen: rd_valid && (rd != '0), is_load: (opcode == OP_LW), valid: 1'b1};

    hazard_scoreboard u_scoreboard (
        .clock_i    (clock),
        .resetn_i   (resetn),
        .id_entry_i (id_entry),
        .en_i       ({En3, En2, En1}),
        .clr_i      ({~reset3, ~reset2, ~reset1}),
        .slot_o     (sb)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hit
            assign hit[gi] = sb_match(sb[gi], rs1, use_rs1) || sb_match(sb[gi], rs2, use_rs2);
        end
    endgenerate

`ifdef HAZARD_FORWARDING_EN
    assign stall_req = hit[0] && sb[0].is_load;
`else
    assign stall_req = |hit;
`endif

    // The slot after a redirect is already a bubble, so a repeated PCSelR is stale.
    assign redirect = PCSelR && (state_q != FLUSH);

    always_comb begin
        PCEn         = 1'b1;
        IFIDEn       = 1'b1;
        En1          = 1'b1;
        En2          = 1'b1;
        En3          = 1'b1;
        reset1       = 1'b1;
        flush_ifid_n = 1'b1;
        if (resetn) begin
            if (!dmem_ready) begin
                PCEn   = 1'b0;
                IFIDEn = 1'b0;
                En1    = 1'b0;
                En2    = 1'b0;
                En3    = 1'b0;
            end else if (redirect) begin
                flush_ifid_n = 1'b0;
                reset1       = 1'b0;
            end else if (stall_req) begin
                PCEn   = 1'b0;
                IFIDEn = 1'b0;
                reset1 = 1'b0;
            end
        end
    end

    assign reset2 = 1'b1;
    assign reset3 = 1'b1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= RUN;
        end else if (dmem_ready) begin
            if (redirect) begin
                state_q <= FLUSH;
            end else if (stall_req) begin
                state_q <= STALL;
            end else begin
                state_q <= RUN;
            end
        end
    end

`ifdef HAZARD_FORWARDING_EN
    // Sources of the instruction now in EX; forwarding is resolved against the slots ahead of it.
    logic [REGBITS-1:0] ex_rs1_q;
    logic [REGBITS-1:0] ex_rs2_q;
    logic               ex_use1_q;
    logic               ex_use2_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            ex_use1_q <= 1'b0;
            ex_use2_q <= 1'b0;
        end else if (En1) begin
            ex_rs1_q  <= reset1 ? rs1 : '0;
            ex_rs2_q  <= reset1 ? rs2 : '0;
            ex_use1_q <= reset1 && use_rs1;
            ex_use2_q <= reset1 && use_rs2;
        end
    end

    always_comb begin
        fwdA = FWD_REG;
        fwdB = FWD_REG;
        if (sb_match(sb[1], ex_rs1_q, ex_use1_q)) begin
            fwdA = FWD_MEM;
        end else if (sb_match(sb[2], ex_rs1_q, ex_use1_q)) begin
            fwdA = FWD_WB;
        end
        if (sb_match(sb[1], ex_rs2_q, ex_use2_q)) begin
            fwdB = FWD_MEM;
        end else if (sb_match(sb[2], ex_rs2_q, ex_use2_q)) begin
            fwdB = FWD_WB;
        end
    end

    assign unused_bits = ^{instruction[31:25], instruction[14:12], hit[2:1],
                           sb[1].is_load, sb[2].is_load};
`else
    assign fwdA = FWD_REG;
    assign fwdB = FWD_REG;

    assign unused_bits = ^{instruction[31:25], instruction[14:12],
                           sb[0].is_load, sb[1].is_load, sb[2].is_load};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random
// instruction streams compared against an in-flight-instruction reference model.
module tb_hazard_controller;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] instruction;
    logic        PCSelR;
    logic        dmem_ready;
    logic        PCEn, IFIDEn, En1, En2, En3;
    logic        reset1, reset2, reset3, flush_ifid_n;
    logic [1:0]  fwdA, fwdB;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;
    int freeze_cycles = 0;

    always #5 clock = ~clock;

    hazard_controller dut (
        .clock        (clock),
        .resetn       (resetn),
        .instruction  (instruction),
        .PCSelR       (PCSelR),
        .dmem_ready   (dmem_ready),
        .PCEn         (PCEn),
        .IFIDEn       (IFIDEn),
        .En1          (En1),
        .En2          (En2),
        .En3          (En3),
        .reset1       (reset1),
        .reset2       (reset2),
        .reset3       (reset3),
        .flush_ifid_n (flush_ifid_n),
        .fwdA         (fwdA),
        .fwdB         (fwdB)
    );

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Model: each in-flight instruction as {valid, dest (0 = none), load, sources (0 = none)}.
    typedef struct {
        bit v;
        int rd;
        bit ld;
        int rs1;
        int rs2;
    } op_t;

    op_t pipe [3];
    bit  m_flush;
    bit  e_pcen, e_ifid, e_en1, e_en2, e_en3, e_r1, e_fl, e_redir;
    logic [1:0] e_fa, e_fb;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic op_t bubble();
        op_t o;
        o.v = 1'b0; o.rd = 0; o.ld = 1'b0; o.rs1 = 0; o.rs2 = 0;
        return o;
    endfunction

    function automatic op_t dec(logic [31:0] ins);
        op_t o = bubble();
        int  d = int'(ins[11:7]);
        int  a = int'(ins[19:15]);
        int  b = int'(ins[24:20]);
        o.v = 1'b1;
        case (ins[6:0])
            7'h33:        begin o.rd = d; o.rs1 = a; o.rs2 = b; end
            7'h13, 7'h67: begin o.rd = d; o.rs1 = a; end
            7'h03:        begin o.rd = d; o.rs1 = a; o.ld = 1'b1; end
            7'h23, 7'h63: begin o.rs1 = a; o.rs2 = b; end
            7'h6f:        o.rd = d;
            default:      ;
        endcase
        return o;
    endfunction

    function automatic bit writes(op_t p, int r);
        return p.v && (p.rd != 0) && (p.rd == r);
    endfunction

    function automatic logic [1:0] fsel(int r);
        if (writes(pipe[1], r)) return 2'b01;
        if (writes(pipe[2], r)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = bubble();
        m_flush = 1'b0;
    endfunction

    function automatic void model_eval();
        op_t id = dec(instruction);
        bit  hz = 1'b0;
        if (FWD) begin
            hz = pipe[0].ld && (writes(pipe[0], id.rs1) || writes(pipe[0], id.rs2));
        end else begin
            for (int k = 0; k < 3; k++)
                if (writes(pipe[k], id.rs1) || writes(pipe[k], id.rs2)) hz = 1'b1;
        end
        e_redir = PCSelR && !m_flush;
        {e_pcen, e_ifid, e_en1, e_en2, e_en3, e_r1, e_fl} = 7'b111_1111;
        if (resetn) begin
            if (!dmem_ready) begin
                {e_pcen, e_ifid, e_en1, e_en2, e_en3} = 5'b00000;
            end else if (e_redir) begin
                e_fl = 1'b0;
                e_r1 = 1'b0;
            end else if (hz) begin
                e_pcen = 1'b0;
                e_ifid = 1'b0;
                e_r1   = 1'b0;
            end
        end
        e_fa = FWD ? fsel(pipe[0].rs1) : 2'b00;
        e_fb = FWD ? fsel(pipe[0].rs2) : 2'b00;
    endfunction

    function automatic void model_advance();
        if (resetn && dmem_ready) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e_r1 ? dec(instruction) : bubble();
            m_flush = e_redir;
        end
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        model_eval();
        check({tag, "/en"},  {3'b0, PCEn, IFIDEn, En1, En2, En3}, {3'b0, e_pcen, e_ifid, e_en1, e_en2, e_en3});
        check({tag, "/clr"}, {4'b0, reset1, reset2, reset3, flush_ifid_n}, {4'b0, e_r1, 1'b1, 1'b1, e_fl});
        check({tag, "/fwd"}, {4'b0, fwdA, fwdB}, {4'b0, e_fa, e_fb});
        $display("step %-10s ins=%08h pcsel=%0b rdy=%0b -> PCEn=%0b IFIDEn=%0b En=%0b%0b%0b r1=%0b fl=%0b fwdA=%0b fwdB=%0b",
                 tag, instruction, PCSelR, dmem_ready, PCEn, IFIDEn, En1, En2, En3, reset1, flush_ifid_n, fwdA, fwdB);
    endtask

    task automatic step(input string tag, input logic [31:0] ins, input logic pc, input logic rdy);
        instruction = ins;
        PCSelR      = pc;
        dmem_ready  = rdy;
        @(negedge clock);
        check_outputs(tag);
        if (PCEn === 1'b0 && rdy) stall_cycles++;
        if (En1 === 1'b0) freeze_cycles++;
        @(posedge clock);
        model_advance();
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) step("drain", NOP, 1'b0, 1'b1);
        stall_cycles  = 0;
        freeze_cycles = 0;
    endtask

    function automatic logic [31:0] r_op(logic [6:0] f7, logic [4:0] rd, logic [4:0] a, logic [4:0] b);
        return {f7, b, a, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw_op(logic [4:0] rd, logic [4:0] a);
        return {12'd0, a, 3'b010, rd, 7'b0000011};
    endfunction

    initial begin
        logic [31:0] rins;
        logic [6:0]  ops [8];
        ops = '{7'h33, 7'h13, 7'h23, 7'h03, 7'h63, 7'h6f, 7'h67, 7'h37};

        // Reset state, with inputs that would otherwise freeze/flush
        resetn      = 1'b0;
        instruction = r_op(7'h00, 5'd3, 5'd1, 5'd2);
        PCSelR      = 1'b1;
        dmem_ready  = 1'b0;
        model_reset();
        @(negedge clock);
        check_outputs("reset");
        @(posedge clock);
        #1;
        resetn = 1'b1;
        drain();

        // lw x5,0(x1) ; add x6,x5,x2
        step("t1_lw", lw_op(5'd5, 5'd1), 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step("t1_add", r_op(7'h00, 5'd6, 5'd5, 5'd2), 1'b0, 1'b1);
        step("t1_nop", NOP, 1'b0, 1'b1);
        check("t1_stalls", 8'(stall_cycles), FWD ? 8'd1 : 8'd3);
        drain();

        // add x5,x1,x2 ; sub x7,x5,x5
        step("t2_add", r_op(7'h00, 5'd5, 5'd1, 5'd2), 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step("t2_sub", r_op(7'h20, 5'd7, 5'd5, 5'd5), 1'b0, 1'b1);
        step("t2_nop", NOP, 1'b0, 1'b1);
        check("t2_stalls", 8'(stall_cycles), FWD ? 8'd0 : 8'd3);
        drain();

        // Redirect together with a load-use request; repeated PCSelR in FLUSH is ignored
        step("t4_lw", lw_op(5'd5, 5'd1), 1'b0, 1'b1);
        step("t4_redir", r_op(7'h00, 5'd6, 5'd5, 5'd2), 1'b1, 1'b1);
        step("t4_again", NOP, 1'b1, 1'b1);
        step("t4_nop", NOP, 1'b0, 1'b1);
        check("t4_stalls", 8'(stall_cycles), 8'd0);
        drain();

        // Data memory wait with a load in MEM
        step("t5_lw", lw_op(5'd5, 5'd1), 1'b0, 1'b1);
        step("t5_nop", NOP, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step("t5_wait", r_op(7'h00, 5'd6, 5'd5, 5'd2), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step("t5_go", r_op(7'h00, 5'd6, 5'd5, 5'd2), 1'b0, 1'b1);
        check("t5_freeze", 8'(freeze_cycles), 8'd4);
        drain();

        // Reset asserted while stalled
        step("t6_lw", lw_op(5'd5, 5'd1), 1'b0, 1'b1);
        instruction = r_op(7'h00, 5'd6, 5'd5, 5'd2);
        @(negedge clock);
        check_outputs("t6_stall");
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check_outputs("t6_async");
        @(posedge clock);
        #1;
        resetn = 1'b1;
        stall_cycles = 0;
        step("t6_redir", r_op(7'h00, 5'd6, 5'd5, 5'd2), 1'b1, 1'b1);
        step("t6_nop", NOP, 1'b0, 1'b1);
        check("t6_stalls", 8'(stall_cycles), 8'd0);
        drain();

        // x0 never creates a dependency
        step("t7_a", r_op(7'h00, 5'd0, 5'd1, 5'd2), 1'b0, 1'b1);
        step("t7_b", r_op(7'h00, 5'd3, 5'd0, 5'd0), 1'b0, 1'b1);
        step("t7_c", NOP, 1'b0, 1'b1);
        check("t7_stalls", 8'(stall_cycles), 8'd0);
        drain();

        // Random streams over a small register set so dependencies are frequent
        rins = NOP;
        for (int n = 0; n < 400; n++) begin
            if (e_ifid || !e_en1) begin
                rins = $urandom();
                rins[6:0]   = ops[$urandom_range(0, 7)];
                rins[11:7]  = 5'($urandom_range(0, 4));
                rins[19:15] = 5'($urandom_range(0, 4));
                rins[24:20] = 5'($urandom_range(0, 4));
            end
            step("rand", rins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
